wormhole_out_lock: RTL

// - Output-port stage of the router; one instance per output port, directly downstream of the port's round-robin arbiter.
// - Offers head-flit requests to the arbiter and consumes its one-hot grant.
// - Locks the winning input for the whole wormhole packet (head..tail) and pushes its flits into a 1-entry output register.
// - Drives the arbiter update strobe once per packet, so priority only rotates on packet boundaries.

---
 rtl/wormhole_out_lock.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/wormhole_out_lock.sv
// ---------------------------------------------------------------------------
// wormhole_out_lock
//
// Output-port stage of a wormhole router. There is one instance per output
// port, and it sits directly downstream of that port's round-robin arbiter.
//
// Operation:
//   - Only head flits (HEAD or HEAD_TAIL) raise a request to the arbiter.
//   - The input that wins the grant is locked for the whole packet, from its
//     head flit through its tail flit.
//   - Every accepted flit is pushed into a 1-entry output register.
//   - The arbiter update strobe fires once per packet, on the head, so the
//     arbiter priority rotates only on packet boundaries.
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   arst_n        asynchronous active-low reset
//   in_valid_i    per-input flit valid                       [N]
//   in_flit_i     per-input flit, input i at [i*FW +: FW]     [N*FW]
//   in_ready_o    per-input ready, at most one bit set        [N]
//   arb_req_o     head-flit requests to the arbiter           [N]
//   arb_grant_i   one-hot combinational grant from arbiter    [N]
//   arb_update_o  arbiter priority-update strobe
//   out_valid_o   output flit valid
//   out_flit_o    output flit                                 [FW]
//   out_ready_i   downstream ready
//   lock_o        current packet owner, one-hot, 0 when idle  [N]
//   err_o         sticky protocol-error flag
// ---------------------------------------------------------------------------
module wormhole_out_lock #(
  parameter int N_OF_INPUTS = 4,
  parameter int FLIT_DATA_W = 32
) (
  input  logic                                    clk,
  input  logic                                    arst_n,
  input  logic [N_OF_INPUTS-1:0]                  in_valid_i,
  input  logic [N_OF_INPUTS*(FLIT_DATA_W+2)-1:0]  in_flit_i,
  output logic [N_OF_INPUTS-1:0]                  in_ready_o,
  output logic [N_OF_INPUTS-1:0]                  arb_req_o,
  input  logic [N_OF_INPUTS-1:0]                  arb_grant_i,
  output logic                                    arb_update_o,
  output logic                                    out_valid_o,
  output logic [FLIT_DATA_W+1:0]                  out_flit_o,
  input  logic                                    out_ready_i,
  output logic [N_OF_INPUTS-1:0]                  lock_o,
  output logic                                    err_o
);

  localparam int N  = N_OF_INPUTS;
  localparam int FW = FLIT_DATA_W + 2;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  localparam logic [1:0] TYPE_HEAD      = 2'b00;
  localparam logic [1:0] TYPE_BODY      = 2'b01;
  localparam logic [1:0] TYPE_TAIL      = 2'b10;
  localparam logic [1:0] TYPE_HEAD_TAIL = 2'b11;

  logic [0:0]    state_ff, state_nxt;
  logic [N-1:0]  lock_ff, lock_nxt;
  logic          out_valid_ff;
  logic [FW-1:0] out_flit_ff;
  logic          err_ff;

  logic          accept;
  logic [N-1:0]  is_head;
  logic [N-1:0]  sel;
  logic [N-1:0]  xfer;
  logic          fire;
  logic [FW-1:0] mux_flit;
  logic [1:0]    mux_type;
  logic          err_set;

  // Request generation, grant qualification and handshake steering.
  // The output register can take a new flit when it is empty or is being
  // drained this cycle. xfer marks the single input whose flit moves this
  // cycle. Because of that, the flit mux below is a plain one-hot OR.
  always_comb begin
    accept       = !out_valid_ff | out_ready_i;
    arb_req_o    = '0;
    in_ready_o   = '0;
    arb_update_o = 1'b0;
    sel          = '0;
    err_set      = 1'b0;
    state_nxt    = state_ff;
    lock_nxt     = lock_ff;
    mux_flit     = '0;

    for (int i = 0; i < N; i++) begin
      is_head[i] = (in_flit_i[i*FW + FW-2 +: 2] == TYPE_HEAD) ||
                   (in_flit_i[i*FW + FW-2 +: 2] == TYPE_HEAD_TAIL);
    end

    if (state_ff == IDLE) begin
      arb_req_o = in_valid_i & is_head;
      sel       = arb_grant_i & arb_req_o;
      if ($onehot(sel)) begin
        if (accept) begin
          in_ready_o   = sel;
          arb_update_o = 1'b1;
        end
      end else if (|arb_req_o) begin
        err_set = 1'b1;
      end
    end else begin
      in_ready_o = lock_ff & {N{accept}};
    end

    xfer = in_ready_o & in_valid_i;
    fire = |xfer;
    for (int i = 0; i < N; i++) begin
      if (xfer[i]) begin
        mux_flit = mux_flit | in_flit_i[i*FW +: FW];
      end
    end
    mux_type = mux_flit[FW-1 -: 2];

    // Packet framing. A HEAD takes the lock and a TAIL releases it.
    // A head flit that arrives from the owner of a locked packet is still
    // forwarded, but it is flagged as a protocol error.
    if (fire) begin
      if (state_ff == IDLE) begin
        if (mux_type == TYPE_HEAD) begin
          state_nxt = LOCKED;
          lock_nxt  = xfer;
        end
      end else begin
        case (mux_type)
          TYPE_TAIL: begin
            state_nxt = IDLE;
            lock_nxt  = '0;
          end
          TYPE_HEAD, TYPE_HEAD_TAIL: err_set = 1'b1;
          TYPE_BODY: ;
          default: ;
        endcase
      end
    end
  end

  // State, lock owner, output register and the sticky error flag.
  // The output register loads whenever a handshake happens. Otherwise it
  // empties when downstream takes the flit. The flit payload is held
  // between loads.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_ff     <= IDLE;
      lock_ff      <= '0;
      out_valid_ff <= 1'b0;
      out_flit_ff  <= '0;
      err_ff       <= 1'b0;
    end else begin
      state_ff <= state_nxt;
      lock_ff  <= lock_nxt;
      if (fire) begin
        out_valid_ff <= 1'b1;
        out_flit_ff  <= mux_flit;
      end else if (out_ready_i) begin
        out_valid_ff <= 1'b0;
      end
      if (err_set) begin
        err_ff <= 1'b1;
      end
    end
  end

  assign out_valid_o = out_valid_ff;
  assign out_flit_o  = out_flit_ff;
  assign lock_o      = lock_ff;
  assign err_o       = err_ff;

endmodule
